// File: rtl/hmem_arbiter.sv
// -----------------------------------------------------------------------------
// hmem_arbiter
//
// Shares a single higher-memory port between the instruction cache
// (requester 0) and the data cache (requester 1). A requester holds its
// rq_valid high for a whole miss sequence (writeback, then allocate, or a
// flush). The arbiter locks the grant to that requester until it drops
// rq_valid. Contention from idle is resolved round-robin against last_grant.
// A hand-over to a waiting requester happens on the same edge, with no idle
// bubble in between.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   rq_valid[1:0]       per-requester request valid
//   rq_operation[1:0]   per-requester LOAD/STORE
//   rq_address[1:0]     per-requester word address
//   rq_wdata[1:0]       per-requester store word
//   rq_fulfilled[1:0]   per-requester fulfilled pulse (only the owner sees it)
//   rq_rdata            load data, broadcast to both requesters
//   mem_*               request to and response from higher memory
//   grant[1:0]          one-hot current owner, 00 when idle
//   timeout_error       sticky flag: memory stalled for WATCHDOG_CYCLES
// -----------------------------------------------------------------------------

package torrence_types;
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } mem_op_e;
endpackage

module hmem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int XLEN            = 32,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [1:0]                         rq_valid,
  input  torrence_types::mem_op_e [1:0]      rq_operation,
  input  logic [1:0][ADDR_W-1:0]             rq_address,
  input  logic [1:0][XLEN-1:0]               rq_wdata,
  output logic [1:0]                         rq_fulfilled,
  output logic [XLEN-1:0]                    rq_rdata,
  output logic                               mem_valid,
  output torrence_types::mem_op_e            mem_operation,
  output logic [ADDR_W-1:0]                  mem_address,
  output logic [XLEN-1:0]                    mem_wdata,
  input  logic                               mem_fulfilled,
  input  logic [XLEN-1:0]                    mem_rdata,
  output logic [1:0]                         grant,
  output logic                               timeout_error
);

  import torrence_types::*;

  // A zero-cycle watchdog is disabled. The counter is kept 1 bit wide in that
  // case so that no zero-width vector is declared.
  localparam bit            WD_EN  = (WATCHDOG_CYCLES != 0);
  localparam int            WD_W   = WD_EN ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } state_e;

  state_e          r_state;
  logic            r_last_grant;   // 1 = requester 1 owned the port last
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  logic            w_granted;
  logic            w_rr_winner;    // requester index chosen from ST_IDLE

  assign w_granted = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);

  // A lone requester wins outright. Under contention the requester that did
  // not own the port last wins.
  assign w_rr_winner = (rq_valid == 2'b11) ? ~r_last_grant : rq_valid[1];

  assign rq_rdata      = mem_rdata;
  assign timeout_error = r_timeout;

  // ---------------------------------------------------------------------------
  // State, round-robin pointer and watchdog
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses <= so that each one samples the values
  // that were present before the edge. A later assignment in this block
  // overrides an earlier one in the same cycle. The grant-entry clear of
  // r_wd_cnt relies on that override.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_wd_cnt     <= '0;
      r_timeout    <= 1'b0;
    end else begin
      // The watchdog runs in either grant state. The count restarts on every
      // completed beat and stops at WD_MAX.
      if (w_granted) begin
        if (mem_fulfilled) begin
          r_wd_cnt <= '0;
        end else if (WD_EN && (r_wd_cnt != WD_MAX)) begin
          r_wd_cnt <= r_wd_cnt + WD_ONE;
          if (r_wd_cnt == (WD_MAX - WD_ONE)) begin
            r_timeout <= 1'b1;
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (|rq_valid) begin
            r_state      <= w_rr_winner ? ST_GRANT1 : ST_GRANT0;
            r_last_grant <= w_rr_winner;
            r_wd_cnt     <= '0;
          end
        end

        ST_GRANT0: begin
          if (!rq_valid[0]) begin
            if (rq_valid[1]) begin
              r_state      <= ST_GRANT1;
              r_last_grant <= 1'b1;
              r_wd_cnt     <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        ST_GRANT1: begin
          if (!rq_valid[1]) begin
            if (rq_valid[0]) begin
              r_state      <= ST_GRANT0;
              r_last_grant <= 1'b0;
              r_wd_cnt     <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          // Propagate an illegal state, so that it is visible in simulation.
          r_state <= state_e'(2'bxx);
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request mux and response routing
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case. This gives each path
  // an assignment, so no latch is inferred.
  always_comb begin
    mem_valid     = 1'b0;
    mem_operation = LOAD;
    mem_address   = '0;
    mem_wdata     = '0;
    rq_fulfilled  = 2'b00;
    grant         = 2'b00;

    case (r_state)
      ST_IDLE: begin
        // Requests are seen here but not forwarded. A stray mem_fulfilled is
        // dropped.
      end

      ST_GRANT0: begin
        mem_valid       = rq_valid[0];
        mem_operation   = rq_operation[0];
        mem_address     = rq_address[0];
        mem_wdata       = rq_wdata[0];
        rq_fulfilled[0] = mem_fulfilled;
        grant           = 2'b01;
      end

      ST_GRANT1: begin
        mem_valid       = rq_valid[1];
        mem_operation   = rq_operation[1];
        mem_address     = rq_address[1];
        mem_wdata       = rq_wdata[1];
        rq_fulfilled[1] = mem_fulfilled;
        grant           = 2'b10;
      end

      default: begin
        mem_valid     = 1'bx;
        mem_operation = mem_op_e'(2'bxx);
        mem_address   = 'x;
        mem_wdata     = 'x;
        rq_fulfilled  = 2'bxx;
        grant         = 2'bxx;
      end
    endcase
  end

endmodule

// File: doc/hmem_arbiter.md
Name: hmem_arbiter

Overview:
- Shares one higher-memory port between two cache controllers: requester 0 is the instruction cache, requester 1 is the data cache.
- Each cache drives a request/fulfilled handshake and holds req_valid high for a whole miss sequence (writeback, then allocate, or flush).
- The arbiter grants one requester at a time with round-robin fairness and locks the grant until that requester drops req_valid.
- It forwards the granted request to memory, routes fulfilled/data back only to the granted requester, and flags a stalled memory with a watchdog.

Parameters:
- ADDR_W, 32, width of the word address carried to higher memory
- XLEN, 32, data word width
- WATCHDOG_CYCLES, 1024, consecutive granted cycles with no mem_fulfilled before timeout_error sets; 0 disables the watchdog

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- rq_valid  input  2  per-requester request valid (bit i = requester i)
- rq_operation  input  2x2  per-requester memory operation, encoded with the memory-operation enum from torrence_types (LOAD/STORE)
- rq_address  input  2xADDR_W  per-requester word address
- rq_wdata  input  2xXLEN  per-requester store word
- rq_fulfilled  output  2  per-requester fulfilled pulse
- rq_rdata  output  XLEN  load data, broadcast to both requesters; valid only with that requester's rq_fulfilled
- mem_valid  output  1  request valid to higher memory
- mem_operation  output  2  operation to higher memory
- mem_address  output  ADDR_W  address to higher memory
- mem_wdata  output  XLEN  store word to higher memory
- mem_fulfilled  input  1  higher memory completed the current beat
- mem_rdata  input  XLEN  load data from higher memory
- grant  output  2  one-hot current owner; 00 when idle
- timeout_error  output  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous and active-low on reset_n. Assertion forces, immediately and mid-burst included:
  - state=ST_IDLE, last_grant=1, watchdog count=0, timeout_error=0
  - combinational outputs then give mem_valid=0, mem_operation=LOAD, mem_address=0, mem_wdata=0, rq_fulfilled=00, grant=00
- rq_rdata equals mem_rdata at all times.
- State machine, registered: ST_IDLE, ST_GRANT0, ST_GRANT1.
- ST_IDLE:
  - No rq_valid: stay in ST_IDLE.
  - Exactly one rq_valid set: go to that requester's grant state.
  - Both set: grant the requester that is not last_grant.
  - On entering a grant state, last_grant is set to the winner.
  - Arbitration latency is one cycle: a request seen in ST_IDLE reaches mem_valid on the next cycle.
- ST_GRANTi:
  - mem_valid/operation/address/wdata come combinationally from requester i.
  - rq_fulfilled[i] = mem_fulfilled; rq_fulfilled for the other requester = 0.
  - grant = one-hot i.
- Leaving ST_GRANTi:
  - Trigger: rq_valid[i]=0 at a clock edge.
  - If the other requester is valid, go directly to its grant state (no idle bubble) and update last_grant.
  - Otherwise go to ST_IDLE.
  - While rq_valid[i]=1 the grant never changes, including across writeback-to-allocate and any number of beats.
- Outputs that are not granted: mem_valid=0, mem_operation=LOAD, mem_address=0, mem_wdata=0. In ST_IDLE mem_valid=0 even if rq_valid is high.
- mem_fulfilled in ST_IDLE is ignored and reaches no requester.
- Watchdog:
  - Counter clears on entry to any grant state and on every mem_fulfilled.
  - It increments each cycle in a grant state while mem_fulfilled=0 and saturates at WATCHDOG_CYCLES.
  - Reaching WATCHDOG_CYCLES sets timeout_error, which stays set until reset.
  - Grant behaviour is unchanged by timeout.
  - Counter is ceil(log2(WATCHDOG_CYCLES+1)) bits.
- An illegal state value drives all outputs to x and next state to x.

Test Plan:
- Single requester:
  - Stimulus: after reset, rq_valid=01, LOAD, address 0x40; mem_fulfilled pulses on 4 beats, then rq_valid drops.
  - Required: grant=01 one cycle after request; rq_fulfilled[0] mirrors mem_fulfilled exactly 4 times; rq_fulfilled[1] stays 0; state returns to idle with grant=00.
- Simultaneous first request:
  - Stimulus: rq_valid=11 from idle right after reset.
  - Required: requester 0 is granted first (last_grant reset=1); when rq_valid[0] drops, grant goes to 10 on the next edge with no idle cycle.
- Round-robin fairness:
  - Stimulus: both requesters repeatedly issue 1-beat requests, each re-asserting rq_valid immediately after release.
  - Required: grant alternates 01,10,01,10 over 8 transactions.
- Burst lock:
  - Stimulus: requester 1 does a STORE writeback of 4 beats, then a LOAD allocate of 4 beats with rq_valid continuously high; rq_valid[0] is asserted mid-burst.
  - Required: grant stays 10 for all 8 beats; mem_operation changes STORE to LOAD; requester 0 is granted only after rq_valid[1] drops.
- Watchdog:
  - Stimulus: WATCHDOG_CYCLES=8, grant active, mem_fulfilled held 0.
  - Required: timeout_error rises after 8 granted cycles and stays set after the burst ends.
  - Stimulus: repeat with a fulfilled pulse every 7 cycles.
  - Required: timeout_error never sets.
- Reset mid-burst:
  - Stimulus: reset_n asserted asynchronously mid-clock during ST_GRANT1.
  - Required: mem_valid and grant drop to 0 before the next clk edge; after release with rq_valid=11, requester 0 wins.
